// File: rtl/sd_bus_arbiter_if.sv
// Signal bundle between sd_bus_arbiter, the user request side, the three SD engines and the card pins.
// The arbiter takes the master modport; the surrounding logic (or a bench) takes the slave modport.
interface sd_bus_arbiter_if #(
    parameter int ADDR_W = 32
) ();

    // Handshake: wr_start/rd_start are single-cycle requests with the address valid in the
    // same cycle (no ready; a request that arrives while one is already pending is dropped).
    // wr_en/rd_en are single-cycle engine strobes; engines answer by raising *_busy, and the
    // arbiter answers the user with single-cycle *_done or start_err pulses.
    logic              init_end;
    logic              init_cs_n;
    logic              init_mosi;

    logic              wr_start;
    logic [ADDR_W-1:0] wr_addr_in;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_addr_in;

    logic              wr_busy;
    logic              wr_cs_n;
    logic              wr_mosi;
    logic              rd_busy;
    logic              rd_cs_n;
    logic              rd_mosi;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic              cs_n;
    logic              mosi;
    logic              ready;
    logic              wr_done;
    logic              rd_done;
    logic              start_err;

    modport master (
        input  init_end, init_cs_n, init_mosi,
        input  wr_start, wr_addr_in, rd_start, rd_addr_in,
        input  wr_busy, wr_cs_n, wr_mosi, rd_busy, rd_cs_n, rd_mosi,
        output wr_en, rd_en, wr_addr, rd_addr,
        output cs_n, mosi, ready, wr_done, rd_done, start_err
    );

    modport slave (
        output init_end, init_cs_n, init_mosi,
        output wr_start, wr_addr_in, rd_start, rd_addr_in,
        output wr_busy, wr_cs_n, wr_mosi, rd_busy, rd_cs_n, rd_mosi,
        input  wr_en, rd_en, wr_addr, rd_addr,
        input  cs_n, mosi, ready, wr_done, rd_done, start_err
    );

endinterface

// File: rtl/sd_bus_arbiter.sv
// sd_bus_arbiter: sequences the single SD-card SPI link between the init, write and read engines.
// Build option: define SD_ARB_ROUND_ROBIN_EN to alternate write/read grants under contention.
module sd_bus_arbiter #(
    parameter int         ADDR_W    = 32,
    parameter logic [3:0] START_TMO = 4'd8
) (
    input  logic             sys_clk_shift,
    input  logic             sys_rst_n,
    sd_bus_arbiter_if.master bus,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WR_GO  = 3'd2,
        ST_WR_ACT = 3'd3,
        ST_RD_GO  = 3'd4,
        ST_RD_ACT = 3'd5
    } state_e;

    localparam logic [3:0] TMO_LAST = START_TMO - 4'd1;

    state_e            state_q, state_d;

    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_cap_q, wr_cap_d;
    logic [ADDR_W-1:0] rd_cap_q, rd_cap_d;

    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              err_q, err_d;

    logic              seen_q, seen_d;
    logic [3:0]        tmo_q, tmo_d;

    logic              grant_wr;
    logic              grant_rd;
    logic              in_act;
    logic              act_busy;
    logic              act_end_ok;
    logic              act_tmo;
    logic              pin_cs_n;
    logic              pin_mosi;

    // Only the busy line of the engine owning the current ACT state is ever looked at.
    always_comb begin
        in_act     = (state_q == ST_WR_ACT) || (state_q == ST_RD_ACT);
        act_busy   = (state_q == ST_WR_ACT) ? bus.wr_busy : bus.rd_busy;
        act_end_ok = in_act && seen_q && !act_busy;
        act_tmo    = in_act && !seen_q && !act_busy && (tmo_q >= TMO_LAST);
    end

`ifdef SD_ARB_ROUND_ROBIN_EN
    logic last_rd_q, last_rd_d;

    // last_rd_q only moves on contended grants, so successive collisions alternate sides.
    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        last_rd_d = last_rd_q;
        if (wr_pend_q && rd_pend_q) begin
            grant_wr = last_rd_q;
            grant_rd = !last_rd_q;
            if (state_q == ST_IDLE) begin
                last_rd_d = !last_rd_q;
            end
        end else begin
            grant_wr = wr_pend_q;
            grant_rd = rd_pend_q;
        end
    end

    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end
`else
    always_comb begin
        grant_wr = wr_pend_q;
        grant_rd = rd_pend_q && !wr_pend_q;
    end
`endif

    // FSM process 1: state register.
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM process 2: next state. A fall of init_end after start-up is deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (bus.init_end) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (grant_wr) begin
                    state_d = ST_WR_GO;
                end else if (grant_rd) begin
                    state_d = ST_RD_GO;
                end
            end
            ST_WR_GO:  state_d = ST_WR_ACT;
            ST_RD_GO:  state_d = ST_RD_ACT;
            ST_WR_ACT, ST_RD_ACT: begin
                if (act_end_ok || act_tmo) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_INIT;
        endcase
    end

    // FSM process 3: registered strobes, request latches and the start watchdog.
    always_comb begin
        wr_en_d   = (state_q == ST_IDLE) && (state_d == ST_WR_GO);
        rd_en_d   = (state_q == ST_IDLE) && (state_d == ST_RD_GO);
        wr_addr_d = wr_en_d ? wr_cap_q : wr_addr_q;
        rd_addr_d = rd_en_d ? rd_cap_q : rd_addr_q;
        wr_done_d = (state_q == ST_WR_ACT) && act_end_ok;
        rd_done_d = (state_q == ST_RD_ACT) && act_end_ok;
        err_d     = act_tmo;

        seen_d = seen_q;
        tmo_d  = tmo_q;
        if (wr_en_d || rd_en_d) begin
            seen_d = 1'b0;
            tmo_d  = 4'd0;
        end else if (in_act) begin
            if (act_busy) begin
                seen_d = 1'b1;
            end
            if (tmo_q != 4'hF) begin
                tmo_d = tmo_q + 4'd1;
            end
        end

        // The GO cycle frees its own latch, so a request arriving in that cycle is kept.
        wr_pend_d = wr_pend_q;
        wr_cap_d  = wr_cap_q;
        if (state_q == ST_WR_GO) begin
            wr_pend_d = 1'b0;
        end
        if (bus.wr_start && !wr_pend_d) begin
            wr_pend_d = 1'b1;
            wr_cap_d  = bus.wr_addr_in;
        end

        rd_pend_d = rd_pend_q;
        rd_cap_d  = rd_cap_q;
        if (state_q == ST_RD_GO) begin
            rd_pend_d = 1'b0;
        end
        if (bus.rd_start && !rd_pend_d) begin
            rd_pend_d = 1'b1;
            rd_cap_d  = bus.rd_addr_in;
        end
    end

    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_cap_q  <= '0;
            rd_cap_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
            seen_q    <= 1'b0;
            tmo_q     <= 4'd0;
        end else begin
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            wr_cap_q  <= wr_cap_d;
            rd_cap_q  <= rd_cap_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            tmo_q     <= tmo_d;
        end
    end

    // Card pin mux; reset forces the link idle-high without waiting for a clock.
    always_comb begin
        pin_cs_n = 1'b1;
        pin_mosi = 1'b1;
        case (state_q)
            ST_INIT: begin
                pin_cs_n = bus.init_cs_n;
                pin_mosi = bus.init_mosi;
            end
            ST_WR_GO, ST_WR_ACT: begin
                pin_cs_n = bus.wr_cs_n;
                pin_mosi = bus.wr_mosi;
            end
            ST_RD_GO, ST_RD_ACT: begin
                pin_cs_n = bus.rd_cs_n;
                pin_mosi = bus.rd_mosi;
            end
            default: begin
                pin_cs_n = 1'b1;
                pin_mosi = 1'b1;
            end
        endcase
        if (!sys_rst_n) begin
            pin_cs_n = 1'b1;
            pin_mosi = 1'b1;
        end
    end

    assign bus.cs_n      = pin_cs_n;
    assign bus.mosi      = pin_mosi;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.start_err = err_q;
    assign bus.ready     = (state_q == ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Randomised bench for sd_bus_arbiter against a timestamp-based model of grants, engine activity and pins.
// Engines are emulated with a per-grant busy plan (delay before busy, busy length, or never busy).
module tb_sd_bus_arbiter;

    localparam int W     = 32;
    localparam int TMO   = 8;
    localparam int NEVER = 1000;
    localparam int FAR   = 1 << 30;

    // ---------------- clock / reset ----------------
    logic       sys_clk_shift = 1'b0;
    logic       sys_rst_n;
    logic [2:0] dbg_state;

    sd_bus_arbiter_if #(.ADDR_W(W)) bus_if ();

    sd_bus_arbiter #(.ADDR_W(W), .START_TMO(4'd8)) dut (
        .sys_clk_shift (sys_clk_shift),
        .sys_rst_n     (sys_rst_n),
        .bus           (bus_if),
        .dbg_state_o   (dbg_state)
    );

    always #10 sys_clk_shift = ~sys_clk_shift;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];

    bit         in_init;
    int         free_at;
    bit         wr_pend_m, rd_pend_m;
    logic [W-1:0] wr_addr_m, rd_addr_m;
    bit         last_rd_m;
    bit         cur_rd, cur_err;
    int         cur_g, cur_f, cur_d, cur_l;

    // stimulus requested by the sequences for the next cycle
    bit         drv_wr, drv_rd, drv_init_end;
    logic [W-1:0] drv_wr_addr, drv_rd_addr;
    bit         force_plan;
    int         force_d, force_l;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        in_init   = 1'b1;
        free_at   = FAR;
        wr_pend_m = 1'b0;
        rd_pend_m = 1'b0;
        wr_addr_m = '0;
        rd_addr_m = '0;
        last_rd_m = 1'b1;
        cur_rd    = 1'b0;
        cur_err   = 1'b0;
        cur_g     = -100;
        cur_f     = -100;
        cur_d     = 0;
        cur_l     = 0;
        exp_q.delete();
    endtask

    // Engine busy for the granted side in cycle c (sampled at the end of c).
    function automatic bit plan_busy(int c);
        if (cur_err) return 1'b0;
        return (c >= cur_g + 1 + cur_d) && (c <= cur_g + cur_d + cur_l);
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        bit owned, pick_rd, exp_cs, exp_mosi, wr_b, rd_b;
        @(negedge sys_clk_shift);

        // outputs of this cycle
        owned = !in_init && (cyc >= cur_g) && (cyc < cur_f);
        if (in_init) begin
            exp_cs = bus_if.init_cs_n; exp_mosi = bus_if.init_mosi;
        end else if (owned) begin
            exp_cs   = cur_rd ? bus_if.rd_cs_n : bus_if.wr_cs_n;
            exp_mosi = cur_rd ? bus_if.rd_mosi : bus_if.wr_mosi;
        end else begin
            exp_cs = 1'b1; exp_mosi = 1'b1;
        end
        check("ready",     bus_if.ready,     !in_init && (free_at <= cyc));
        check("wr_en",     bus_if.wr_en,     !cur_rd && (cyc == cur_g));
        check("rd_en",     bus_if.rd_en,     cur_rd && (cyc == cur_g));
        check("wr_done",   bus_if.wr_done,   !cur_rd && !cur_err && (cyc == cur_f));
        check("rd_done",   bus_if.rd_done,   cur_rd && !cur_err && (cyc == cur_f));
        check("start_err", bus_if.start_err, cur_err && (cyc == cur_f));
        check("cs_n",      bus_if.cs_n,      exp_cs);
        check("mosi",      bus_if.mosi,      exp_mosi);
        if (bus_if.wr_en || bus_if.rd_en) begin
            check("grant_queued", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0)
                check("grant_side_addr",
                      {bus_if.rd_en, bus_if.rd_en ? bus_if.rd_addr : bus_if.wr_addr},
                      exp_q.pop_front());
        end

        // pending request leaves the latch during its GO cycle
        if (cyc == cur_g) begin
            if (cur_rd) rd_pend_m = 1'b0;
            else        wr_pend_m = 1'b0;
        end

        // arbitration in an idle cycle with something pending
        if (!in_init && (free_at <= cyc) && (wr_pend_m || rd_pend_m)) begin
            if (wr_pend_m && rd_pend_m) begin
`ifdef SD_ARB_ROUND_ROBIN_EN
                pick_rd   = !last_rd_m;
                last_rd_m = pick_rd;
`else
                pick_rd = 1'b0;
`endif
            end else begin
                pick_rd = rd_pend_m;
            end
            cur_rd = pick_rd;
            cur_g  = cyc + 1;
            if (force_plan) begin
                cur_d = force_d; cur_l = force_l;
            end else begin
                cur_d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
                cur_l = $urandom_range(1, 6);
            end
            cur_err = (cur_d >= TMO);
            cur_f   = cur_err ? (cur_g + TMO + 1) : (cur_g + cur_d + cur_l + 2);
            free_at = cur_f;
            exp_q.push_back({pick_rd, pick_rd ? rd_addr_m : wr_addr_m});
        end

        // engine pins: random junk, except the busy plan of the granted engine
        wr_b = 1'($urandom_range(0, 1));
        rd_b = 1'($urandom_range(0, 1));
        if ((cyc > cur_g) && (cyc < cur_f)) begin
            if (cur_rd) rd_b = plan_busy(cyc);
            else        wr_b = plan_busy(cyc);
        end
        bus_if.wr_busy   = wr_b;
        bus_if.rd_busy   = rd_b;
        bus_if.init_cs_n = 1'($urandom_range(0, 1));
        bus_if.init_mosi = 1'($urandom_range(0, 1));
        bus_if.wr_cs_n   = 1'($urandom_range(0, 1));
        bus_if.wr_mosi   = 1'($urandom_range(0, 1));
        bus_if.rd_cs_n   = 1'($urandom_range(0, 1));
        bus_if.rd_mosi   = 1'($urandom_range(0, 1));

        // user requests; a request against a full latch is dropped
        bus_if.wr_start   = drv_wr;
        bus_if.wr_addr_in = drv_wr ? drv_wr_addr : $urandom();
        bus_if.rd_start   = drv_rd;
        bus_if.rd_addr_in = drv_rd ? drv_rd_addr : $urandom();
        if (drv_wr && !wr_pend_m) begin wr_pend_m = 1'b1; wr_addr_m = drv_wr_addr; end
        if (drv_rd && !rd_pend_m) begin rd_pend_m = 1'b1; rd_addr_m = drv_rd_addr; end

        bus_if.init_end = drv_init_end;
        if (in_init && drv_init_end) begin
            in_init = 1'b0;
            free_at = cyc + 1;
        end

        drv_wr = 1'b0;
        drv_rd = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_plan(input int d, input int l);
        force_plan = 1'b1; force_d = d; force_l = l;
    endtask

    // ---------------- sequences ----------------
    initial begin
        sys_rst_n = 1'b0;
        bus_if.init_end = 1'b0;  bus_if.init_cs_n = 1'b1; bus_if.init_mosi = 1'b1;
        bus_if.wr_start = 1'b0;  bus_if.wr_addr_in = '0;
        bus_if.rd_start = 1'b0;  bus_if.rd_addr_in = '0;
        bus_if.wr_busy  = 1'b0;  bus_if.wr_cs_n = 1'b0;   bus_if.wr_mosi = 1'b0;
        bus_if.rd_busy  = 1'b0;  bus_if.rd_cs_n = 1'b0;   bus_if.rd_mosi = 1'b0;
        drv_wr = 1'b0; drv_rd = 1'b0; drv_init_end = 1'b0;
        drv_wr_addr = '0; drv_rd_addr = '0;
        force_plan = 1'b0; force_d = 0; force_l = 0;
        model_reset();

        #25;
        check("rst_wr_en",     bus_if.wr_en,     1'b0);
        check("rst_rd_en",     bus_if.rd_en,     1'b0);
        check("rst_wr_addr",   bus_if.wr_addr,   '0);
        check("rst_rd_addr",   bus_if.rd_addr,   '0);
        check("rst_wr_done",   bus_if.wr_done,   1'b0);
        check("rst_rd_done",   bus_if.rd_done,   1'b0);
        check("rst_start_err", bus_if.start_err, 1'b0);
        check("rst_ready",     bus_if.ready,     1'b0);
        check("rst_cs_n",      bus_if.cs_n,      1'b1);
        check("rst_mosi",      bus_if.mosi,      1'b1);
        @(negedge sys_clk_shift);
        sys_rst_n = 1'b1;

        // initialisation: pins follow the init engine, a read request is held back
        set_plan(1, 3);
        idle(5);
        drv_rd = 1'b1; drv_rd_addr = $urandom();
        idle(15);
        drv_init_end = 1'b1;
        idle(20);

        // single write, long busy
        set_plan(1, 50);
        drv_wr = 1'b1; drv_wr_addr = 32'h0000_0800;
        idle(70);

        // simultaneous write and read, twice
        set_plan(1, 4);
        repeat (2) begin
            drv_wr = 1'b1; drv_wr_addr = $urandom();
            drv_rd = 1'b1; drv_rd_addr = $urandom();
            idle(30);
        end

        // engine never goes busy
        set_plan(NEVER, 1);
        drv_wr = 1'b1; drv_wr_addr = $urandom();
        idle(20);

        // second write while the first is still pending
        set_plan(1, 3);
        drv_wr = 1'b1; drv_wr_addr = 32'h0000_0010;
        cycle();
        drv_wr = 1'b1; drv_wr_addr = 32'h0000_1234;
        idle(20);

        // random traffic; init_end is occasionally dropped and must be ignored
        force_plan = 1'b0;
        repeat (3000) begin
            drv_wr = ($urandom_range(0, 5) == 0);
            drv_rd = ($urandom_range(0, 5) == 0);
            drv_wr_addr = $urandom();
            drv_rd_addr = $urandom();
            if ($urandom_range(0, 99) == 0) drv_init_end = !drv_init_end;
            cycle();
        end
        idle(60);
        check("grants_outstanding", exp_q.size(), 0);

        // reset in the middle of an active write
        set_plan(1, 50);
        drv_wr = 1'b1; drv_wr_addr = $urandom();
        idle(8);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_cs_n",    bus_if.cs_n,    1'b1);
        check("midrst_mosi",    bus_if.mosi,    1'b1);
        check("midrst_wr_en",   bus_if.wr_en,   1'b0);
        check("midrst_ready",   bus_if.ready,   1'b0);
        check("midrst_wr_addr", bus_if.wr_addr, '0);
        model_reset();
        drv_init_end = 1'b0;
        bus_if.init_end = 1'b0;
        bus_if.wr_start = 1'b0;
        bus_if.rd_start = 1'b0;
        @(negedge sys_clk_shift);
        sys_rst_n = 1'b1;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
